// File: rtl/write_response_router.sv
// write_response_router: routes shared B-channel responses to the port the Mapper names.
// Ports: clock/reset, s_b* downstream, look_after/came_from Mapper lookup, m_b* upstream,
//   release_id/release_valid free pulse, route_error sticky, delivered_count wrapping.
module write_response_router #(
  parameter int ID_WIDTH        = 6,
  parameter int NUMBER_OF_PORTS = 2,
  parameter int PORT_WIDTH      =
    (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ID_WIDTH:0]          s_bid,
  input  logic [1:0]                 s_bresp,
  input  logic                       s_bvalid,
  output logic                       s_bready,
  output logic [ID_WIDTH:0]          look_after,
  input  logic [PORT_WIDTH-1:0]      came_from,
  output logic [ID_WIDTH:0]          m_bid,
  output logic [1:0]                 m_bresp,
  output logic [NUMBER_OF_PORTS-1:0] m_bvalid,
  input  logic [NUMBER_OF_PORTS-1:0] m_bready,
  output logic [ID_WIDTH:0]          release_id,
  output logic                       release_valid,
  output logic                       route_error,
  output logic [COUNT_WIDTH-1:0]     delivered_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DELIVER
  } state_t;

  localparam logic [PORT_WIDTH:0] NP_L =
    NUMBER_OF_PORTS[PORT_WIDTH:0];

  state_t                     state_q, state_d;
  logic [ID_WIDTH:0]          id_q, id_d;
  logic [1:0]                 resp_q, resp_d;
  logic [NUMBER_OF_PORTS-1:0] bvalid_q, bvalid_d;
  logic [ID_WIDTH:0]          rel_id_q, rel_id_d;
  logic                       rel_v_q, rel_v_d;
  logic                       err_q, err_d;
  logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                       rdy_q, rdy_d;

  logic [NUMBER_OF_PORTS-1:0] onehot;
  logic                       in_range;
  logic                       hs;

  // bvalid_q is one-hot, so masking ready with it ignores other ports.
  assign hs       = |(bvalid_q & m_bready);
  assign in_range = {1'b0, came_from} < NP_L;

  always_comb begin
    onehot = '0;
    for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
      onehot[p] = (came_from == p[PORT_WIDTH-1:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    resp_d   = resp_q;
    bvalid_d = bvalid_q;
    rel_id_d = rel_id_q;
    rel_v_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_bvalid && rdy_q) begin
          id_d    = s_bid;
          resp_d  = s_bresp;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (in_range) begin
          bvalid_d = onehot;
          state_d  = DELIVER;
        end else begin
          // Unroutable: drop it but still free the mapping.
          err_d    = 1'b1;
          rel_v_d  = 1'b1;
          rel_id_d = id_q;
          state_d  = IDLE;
        end
      end
      DELIVER: begin
        if (hs) begin
          bvalid_d = '0;
          rel_v_d  = 1'b1;
          rel_id_d = id_q;
          cnt_d    = cnt_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: low on the cycle that returns to IDLE.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      resp_q   <= '0;
      bvalid_q <= '0;
      rel_id_q <= '0;
      rel_v_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      resp_q   <= resp_d;
      bvalid_q <= bvalid_d;
      rel_id_q <= rel_id_d;
      rel_v_q  <= rel_v_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

  assign s_bready        = rdy_q;
  assign look_after      = id_q;
  assign m_bid           = id_q;
  assign m_bresp         = resp_q;
  assign m_bvalid        = bvalid_q;
  assign release_id      = rel_id_q;
  assign release_valid   = rel_v_q;
  assign route_error     = err_q;
  assign delivered_count = cnt_q;

endmodule

// File: tb/tb_write_response_router.sv
// Bench for write_response_router: acts as Mapper, drives directed and random traffic,
// checks every cycle against a transaction-level model plus literal expectations.
module tb_write_response_router;
  localparam int IW = 6;
  localparam int NP = 3;
  localparam int PW = 2;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [IW:0]   s_bid, look_after, m_bid, release_id;
  logic [1:0]    s_bresp, m_bresp;
  logic          s_bvalid, s_bready;
  logic [PW-1:0] came_from;
  logic [NP-1:0] m_bvalid, m_bready;
  logic          release_valid, route_error;
  logic [CW-1:0] delivered_count;

  logic [PW-1:0] map_tbl [0:127];

  always #5 clock = ~clock;

  assign came_from = map_tbl[look_after];

  write_response_router #(
    .ID_WIDTH(IW), .NUMBER_OF_PORTS(NP), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .s_bid(s_bid), .s_bresp(s_bresp),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .look_after(look_after), .came_from(came_from),
    .m_bid(m_bid), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .release_id(release_id), .release_valid(release_valid),
    .route_error(route_error),
    .delivered_count(delivered_count)
  );

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one response in flight, tracked by
  // how many edges have passed since it was accepted.
  bit e_busy, e_rdy, e_err, e_rel_v;
  int e_age, e_id, e_resp, e_port, e_cnt, e_rel_id;

  always @(posedge clock) begin
    if (reset) begin
      e_busy = 0; e_rdy = 0; e_err = 0; e_rel_v = 0;
      e_age = 0; e_id = 0; e_resp = 0; e_cnt = 0;
      e_rel_id = 0; e_port = 0;
    end else begin
      e_rel_v = 0;
      if (e_busy) begin
        if (e_age == 0) begin
          e_port = int'(map_tbl[e_id]);
          if (e_port >= NP) begin
            e_err = 1; e_rel_v = 1; e_rel_id = e_id; e_busy = 0;
          end else begin
            e_age = 1;
          end
        end else if (m_bready[e_port]) begin
          e_rel_v = 1; e_rel_id = e_id;
          e_cnt = (e_cnt + 1) % (1 << CW);
          e_busy = 0;
        end
      end else if (e_rdy && s_bvalid) begin
        e_busy = 1; e_age = 0;
        e_id = int'(s_bid); e_resp = int'(s_bresp);
      end
      e_rdy = !e_busy;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("s_bready", s_bready, e_rdy);
      chk("m_bvalid", m_bvalid,
          (e_busy && e_age == 1) ? (1 << e_port) : 0);
      chk("m_bid", m_bid, e_id);
      chk("m_bresp", m_bresp, e_resp);
      chk("look_after", look_after, e_id);
      chk("release_valid", release_valid, e_rel_v);
      if (e_rel_v) chk("release_id", release_id, e_rel_id);
      chk("route_error", route_error, e_err);
      chk("delivered_count", delivered_count, e_cnt);
    end
  end

  task automatic send(input logic [IW:0] id, input logic [1:0] rs);
    s_bvalid = 1'b1; s_bid = id; s_bresp = rs;
    @(negedge clock);
    s_bvalid = 1'b0;
  endtask

  int accepts;

  initial begin
    for (int i = 0; i < 128; i++) map_tbl[i] = '0;
    s_bvalid = 0; s_bid = '0; s_bresp = '0; m_bready = '0;
    reset = 1;
    @(posedge clock);
    #1 checking = 1;
    @(negedge clock);
    chk("rst_bready", s_bready, 0);
    chk("rst_bvalid", m_bvalid, 0);
    chk("rst_cnt", delivered_count, 0);
    chk("rst_rel_id", release_id, 0);
    reset = 0;
    map_tbl[7'h21] = 2'd1;
    map_tbl[7'h20] = 2'd0;
    map_tbl[7'h05] = 2'd3;
    @(negedge clock);
    chk("idle_bready", s_bready, 1);

    send(7'h21, 2'd0);
    chk("lookup_bvalid", m_bvalid, 0);
    chk("lookup_bready", s_bready, 0);
    @(negedge clock);
    chk("t1_bvalid", m_bvalid, 3'b010);
    m_bready = 3'b010;
    @(negedge clock);
    m_bready = '0;
    chk("t1_rel_v", release_valid, 1);
    chk("t1_rel_id", release_id, 7'h21);
    chk("t1_cnt", delivered_count, 1);
    chk("t1_bvalid_off", m_bvalid, 0);
    chk("t1_bready", s_bready, 1);

    send(7'h20, 2'd2);
    m_bready = 3'b010;
    repeat (5) begin
      @(negedge clock);
      chk("t2_hold", m_bvalid, 3'b001);
      chk("t2_bresp", m_bresp, 2);
      chk("t2_no_rel", release_valid, 0);
    end
    m_bready = 3'b001;
    @(negedge clock);
    m_bready = '0;
    chk("t2_rel_v", release_valid, 1);
    chk("t2_rel_id", release_id, 7'h20);
    chk("t2_cnt", delivered_count, 2);

    send(7'h05, 2'd1);
    @(negedge clock);
    chk("err_flag", route_error, 1);
    chk("err_rel_v", release_valid, 1);
    chk("err_rel_id", release_id, 7'h05);
    chk("err_bvalid", m_bvalid, 0);
    @(negedge clock);
    chk("err_sticky", route_error, 1);
    chk("err_pulse_once", release_valid, 0);
    send(7'h21, 2'd3);
    @(negedge clock);
    chk("err_next_bvalid", m_bvalid, 3'b010);
    m_bready = 3'b111;
    @(negedge clock);
    m_bready = '0;
    chk("err_next_cnt", delivered_count, 3);
    chk("err_still", route_error, 1);

    send(7'h20, 2'd0);
    @(negedge clock);
    chk("rd_bvalid", m_bvalid, 3'b001);
    reset = 1;
    @(negedge clock);
    chk("rd_bvalid_off", m_bvalid, 0);
    chk("rd_rel_v", release_valid, 0);
    chk("rd_cnt", delivered_count, 0);
    chk("rd_err", route_error, 0);
    chk("rd_bready", s_bready, 0);
    reset = 0;
    @(negedge clock);
    chk("rd_bready_back", s_bready, 1);

    m_bready = '1;
    s_bvalid = 1; s_bid = 7'h20; s_bresp = 0;
    accepts = 0;
    repeat (12) begin
      if (s_bready) accepts++;
      @(negedge clock);
    end
    chk("b2b_accepts", accepts, 4);
    chk("b2b_cnt", delivered_count, 4);
    repeat (15) @(negedge clock);
    chk("wrap_cnt", delivered_count, 1);
    s_bvalid = 0; m_bready = '0;
    @(negedge clock);

    repeat (4000) begin
      @(negedge clock);
      s_bvalid = 1'($urandom_range(0, 1));
      s_bid    = 7'($urandom);
      s_bresp  = 2'($urandom);
      m_bready = 3'($urandom);
      if ($urandom_range(0, 7) == 0)
        map_tbl[$urandom_range(0, 127)] = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 0;
    @(negedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/write_response_router.md
# write_response_router

Return-path companion of the ID-to-port `Mapper`. It accepts write responses (B channel) from the memory side, queries the `Mapper` through its look-up port for the originating input port of each response ID, and delivers the response to that port only with a valid/ready handshake. After each delivery it emits a release pulse so the `Mapper` can free the entry. It sits between the shared downstream B channel and the per-port upstream B channels of the MemorEDF arbiter.

## Interface
Parameters:
- `ID_WIDTH`, 6, MSB index of the transaction ID; IDs are `ID_WIDTH+1` bits wide, matching the `Mapper`.
- `NUMBER_OF_PORTS`, 2, number of upstream ports.
- `PORT_WIDTH`, max(1, $clog2(NUMBER_OF_PORTS)), width of a port index.
- `COUNT_WIDTH`, 16, width of the delivered-response counter.

Ports (one clock; `reset` is synchronous and active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_bid`  in  ID_WIDTH+1  downstream response ID.
- `s_bresp`  in  2  downstream response code.
- `s_bvalid`  in  1  downstream response valid.
- `s_bready`  out  1  router ready to accept a downstream response.
- `look_after`  out  ID_WIDTH+1  ID presented to the `Mapper` look-up port.
- `came_from`  in  PORT_WIDTH  `Mapper` look-up result, valid one cycle after `look_after`.
- `m_bid`  out  ID_WIDTH+1  ID broadcast to all ports.
- `m_bresp`  out  2  response code broadcast to all ports.
- `m_bvalid`  out  NUMBER_OF_PORTS  one-hot valid, at most one bit set.
- `m_bready`  in  NUMBER_OF_PORTS  per-port ready.
- `release_id`  out  ID_WIDTH+1  ID whose mapping is freed.
- `release_valid`  out  1  single-cycle release pulse.
- `route_error`  out  1  sticky flag: a `came_from` value was out of range.
- `delivered_count`  out  COUNT_WIDTH  number of completed deliveries, wraps.

## Operation
- FSM states: IDLE, LOOKUP, DELIVER. One response is in flight at a time.
- **IDLE**
  - `s_bready`=1.
  - On `s_bvalid`: capture `s_bid`/`s_bresp` into registers, drive the captured ID on `look_after`, go to LOOKUP.
- **LOOKUP**
  - `s_bready`=0.
  - Capture `came_from` into the port register.
  - If `came_from` < NUMBER_OF_PORTS, go to DELIVER.
  - Otherwise set `route_error`, pulse `release_valid` for the captured ID (the response is dropped), and go to IDLE.
- **DELIVER**
  - `m_bvalid[port]`=1; `m_bid`/`m_bresp` hold the captured values.
  - Hold until `m_bready[port]`=1. `m_bready` on other ports is ignored.
  - On the handshake cycle, register a `release_valid` pulse with `release_id` = captured ID, increment `delivered_count` (modulo 2^COUNT_WIDTH), and go to IDLE.
- `look_after` keeps the captured ID from the capture edge until the next capture. Outside LOOKUP it is don't-care for the `Mapper`, but it must stay stable.
- `route_error` clears only on reset.

## Timing
- Reset values:
  - state = IDLE.
  - `s_bready`=0 during the reset cycle, 1 afterwards.
  - `look_after`, `m_bid`, `release_id`, `delivered_count` = 0.
  - `m_bresp`=0, `m_bvalid`=0, `release_valid`=0, `route_error`=0.
- Latency:
  - Downstream handshake at edge N.
  - `came_from` sampled at edge N+1.
  - `m_bvalid` high from after edge N+1.
  - Earliest upstream handshake at edge N+2.
  - `release_valid` high for the cycle after the upstream handshake.
- Maximum throughput: one response per 3 cycles when upstream is always ready.
- `m_bvalid` must not drop, and `m_bid`/`m_bresp` must not change, until the handshake completes.
- `s_bready` is 0 in LOOKUP and DELIVER. Downstream back-pressure is mandatory.
- Simultaneous events: the cycle that returns to IDLE does not accept a new response (`s_bready` is registered from state). Acceptance resumes on the following cycle.
- Reset in any state:
  - Next state is IDLE.
  - The in-flight response is discarded; no release pulse is issued for it.
  - `m_bvalid` is 0 on the next cycle.

## Test plan
- Map 0x21→port 1 and 0x20→port 0. Send `s_bid`=0x21, `s_bresp`=0 → `m_bvalid`=2'b10 two cycles after acceptance; after `m_bready[1]`: `release_id`=0x21 pulses for one cycle; `delivered_count`=1.
- Send `s_bid`=0x20, `s_bresp`=2 with `m_bready`=2'b10 held for 5 cycles, then 2'b01 → `m_bvalid`=2'b01 stays stable for all 5 cycles; handshake occurs only once `m_bready[0]` rises; `m_bresp`=2 throughout.
- Keep `s_bvalid` high for 4 back-to-back responses with all ports ready → `s_bready` is high every third cycle; 4 deliveries occur in 12 cycles; `delivered_count`=4.
- With NUMBER_OF_PORTS=3, force `came_from`=3 → no `m_bvalid`; `route_error`=1 and stays 1; `release_valid` pulses once; the next valid response is delivered normally.
- Assert reset while in DELIVER → next cycle `m_bvalid`=0, `release_valid`=0, `delivered_count`=0; one cycle after reset drops, `s_bready`=1.
- Preset `delivered_count` near wrap (COUNT_WIDTH=2) and complete 5 deliveries → count reads 1.
